// File: rtl/i2s_mic_array_receiver.sv
// ---------------------------------------------------------------------------
// i2s_mic_array_receiver
//   I2S master receiver for n_lines SD lines, each carrying a left and a right
//   microphone. Generates SCK/WS, deserialises w_sample bits per channel (MSB
//   first, one SCK after the WS edge) and presents a whole frame through
//   valid/ready, with a sticky overrun flag.
//
//   Ports:
//     clk, rst_n      system clock, async active-low reset (sync release)
//     sck, ws         I2S bit clock / word select (0 = left, 1 = right)
//     sd[n_lines]     serial data, one bit per line
//     left, right     samples, line i at [i*w_sample +: w_sample], signed
//     valid, ready    frame handshake
//     overrun         sticky: unaccepted frame was overwritten
//     ovr_clr         clears overrun (a coincident new overrun wins)
//     peak            (I2S_MIC_ARRAY_PEAK_EN only) per-channel max |sample|
//                     since last accepted frame, packed as {right, left}
//
//   Optional feature macro: I2S_MIC_ARRAY_PEAK_EN
// ---------------------------------------------------------------------------

// Per-line deserialiser: shift registers, left hold, output and peak regs.
module i2s_mic_lane #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sd,
   input  logic         shift_l,
   input  logic         shift_r,
   input  logic         hold_ld,
   input  logic         load,
   input  logic         accept,
   output logic [W-1:0] left,
   output logic [W-1:0] right
`ifdef I2S_MIC_ARRAY_PEAK_EN
   ,
   output logic [W-1:0] pk_l,
   output logic [W-1:0] pk_r
`endif
);
   logic [W-1:0] sh_l, sh_r, hold;
   logic [W:0]   nxt_l, nxt_r;

   assign nxt_l = {sh_l, sd};
   assign nxt_r = {sh_r, sd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_l  <= '0;
         sh_r  <= '0;
         hold  <= '0;
         left  <= '0;
         right <= '0;
      end else begin
         if (shift_l) sh_l <= nxt_l[W-1:0];
         if (shift_r) sh_r <= nxt_r[W-1:0];
         // left is parked here so the right channel can refill the frame
         if (hold_ld) hold <= sh_l;
         if (load) begin
            left  <= hold;
            right <= sh_r;
         end
      end
   end

`ifdef I2S_MIC_ARRAY_PEAK_EN
   localparam logic [W-1:0] MIN_NEG = W'(1) << (W-1);
   localparam logic [W-1:0] MAX_POS = MIN_NEG - W'(1);

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      if (!v[W-1])         return v;
      else if (v == MIN_NEG) return MAX_POS;
      else                 return -v;
   endfunction

   logic [W-1:0] m_l, m_r;
   assign m_l = mag(hold);
   assign m_r = mag(sh_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pk_l <= '0;
         pk_r <= '0;
      end else if (load) begin
         // an accept on the load edge retires the old window
         pk_l <= (accept || m_l > pk_l) ? m_l : pk_l;
         pk_r <= (accept || m_r > pk_r) ? m_r : pk_r;
      end else if (accept) begin
         pk_l <= '0;
         pk_r <= '0;
      end
   end
`endif
endmodule

module i2s_mic_array_receiver #(
   parameter int sck_half = 4,
   parameter int w_sample = 24,
   parameter int n_lines  = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic                          sck,
   output logic                          ws,
   input  logic [n_lines-1:0]            sd,
   output logic [n_lines*w_sample-1:0]   left,
   output logic [n_lines*w_sample-1:0]   right,
   output logic                          valid,
   input  logic                          ready,
   output logic                          overrun,
   input  logic                          ovr_clr
`ifdef I2S_MIC_ARRAY_PEAK_EN
   ,
   output logic [2*n_lines*w_sample-1:0] peak
`endif
);
   if (sck_half < 2 || w_sample < 1 || w_sample > 31 || n_lines < 1) begin : g_param_err
      $error("i2s_mic_array_receiver: illegal parameter set");
   end

   localparam int DW = $clog2(sck_half);

   logic [1:0]    rst_sync;
   logic          srst_n;
   logic [DW-1:0] div;
   logic [5:0]    bit_cnt, bit_nxt;
   logic          wrap, rise, fall, ch, in_rng, p_last;
   logic          shift_l, shift_r, hold_ld, load, accept;
   logic [4:0]    p;

   // async assert, release synchronised to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign srst_n = rst_sync[1];

   assign wrap    = (div == DW'(sck_half - 1));
   assign rise    = wrap & ~sck;
   assign fall    = wrap & sck;
   assign bit_nxt = bit_cnt + 6'd1;
   assign ch      = bit_cnt[5];
   assign p       = bit_cnt[4:0];
   assign in_rng  = (p != 5'd0) && (p <= 5'(w_sample));
   assign p_last  = (p == 5'(w_sample));
   assign shift_l = rise & ~ch & in_rng;
   assign shift_r = rise & ch & in_rng;
   assign accept  = valid & ready;

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         div     <= '0;
         sck     <= 1'b0;
         bit_cnt <= '0;
         ws      <= 1'b0;
         hold_ld <= 1'b0;
         load    <= 1'b0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         div <= wrap ? '0 : div + DW'(1);
         if (wrap) sck <= ~sck;
         // ws tracks bit_cnt[5], so it only moves on SCK falling edges
         if (fall) begin
            bit_cnt <= bit_nxt;
            ws      <= bit_nxt[5];
         end
         // load/hold fire one clk after the last bit has been shifted in
         hold_ld <= rise & ~ch & p_last;
         load    <= rise & ch & p_last;
         if (load)        valid <= 1'b1;
         else if (accept) valid <= 1'b0;
         overrun <= (load & valid & ~ready) | (overrun & ~ovr_clr);
      end
   end

`ifdef I2S_MIC_ARRAY_PEAK_EN
   logic [n_lines*w_sample-1:0] pk_l, pk_r;
   assign peak = {pk_r, pk_l};
`endif

   for (genvar i = 0; i < n_lines; i++) begin : g_lane
      i2s_mic_lane #(.W(w_sample)) u_lane (
         .clk     (clk),
         .rst_n   (srst_n),
         .sd      (sd[i]),
         .shift_l (shift_l),
         .shift_r (shift_r),
         .hold_ld (hold_ld),
         .load    (load),
         .accept  (accept),
         .left    (left[i*w_sample +: w_sample]),
         .right   (right[i*w_sample +: w_sample])
`ifdef I2S_MIC_ARRAY_PEAK_EN
         ,
         .pk_l    (pk_l[i*w_sample +: w_sample]),
         .pk_r    (pk_r[i*w_sample +: w_sample])
`endif
      );
   end
endmodule

// File: tb/tb_i2s_mic_array_receiver.sv
module tb_i2s_mic_array_receiver;
   localparam int SH = 4;
   localparam int W  = 24;
   localparam int L  = 2;
   localparam int NF = 8;
   localparam int LAST = 32 + W;   // slot of the last right bit in a frame

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sck, ws, valid, overrun;
   logic             ready = 1'b0, ovr_clr = 1'b0;
   logic [L-1:0]     sd;
   logic [L*W-1:0]   left, right;
`ifdef I2S_MIC_ARRAY_PEAK_EN
   logic [2*L*W-1:0] peak;
`endif

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // frame table: the SD model plays frame (n/64)%NF
   logic [W-1:0] tl [NF][L];
   logic [W-1:0] tr [NF][L];
   int n = 0;      // SCK falling edges seen since reset release

   i2s_mic_array_receiver #(.sck_half(SH), .w_sample(W), .n_lines(L)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
      .left(left), .right(right), .valid(valid), .ready(ready),
      .overrun(overrun), .ovr_clr(ovr_clr)
`ifdef I2S_MIC_ARRAY_PEAK_EN
      , .peak(peak)
`endif
   );

   always #5 clk = ~clk;

   // I2S slave model: slot n follows the n-th SCK fall; slot bit p (1..W)
   // of channel s[5] carries sample bit W-p. Unused slots carry noise.
   function automatic logic slot_bit(int nn, int line);
      int s, p, f;
      logic [W-1:0] v;
      s = nn % 64;
      p = s % 32;
      f = (nn / 64) % NF;
      if (p >= 1 && p <= W) begin
         v = (s >= 32) ? tr[f][line] : tl[f][line];
         return v[W-p];
      end
      return 1'($urandom_range(1));
   endfunction

   initial begin : sd_drv
      logic psck;
      psck = 1'b0;
      sd = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            n = 0; psck = 1'b0; sd = '0;
         end else begin
            if (psck && !sck) begin
               n++;
               for (int i = 0; i < L; i++) sd[i] = slot_bit(n, i);
            end
            psck = sck;
         end
      end
   end

   function automatic logic [L*W-1:0] exp_l(int f);
      logic [L*W-1:0] v;
      for (int i = 0; i < L; i++) v[i*W +: W] = tl[f][i];
      return v;
   endfunction

   function automatic logic [L*W-1:0] exp_r(int f);
      logic [L*W-1:0] v;
      for (int i = 0; i < L; i++) v[i*W +: W] = tr[f][i];
      return v;
   endfunction

   function automatic logic [W-1:0] ref_mag(logic [W-1:0] v);
      longint s;
      s = v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
      if (s < 0) s = -s;
      if (s > (longint'(1) << (W-1)) - 1) s = (longint'(1) << (W-1)) - 1;
      return W'(s);
   endfunction

   // expected peak over frames f0..f1, packed {right, left}
   function automatic logic [2*L*W-1:0] exp_pk(int f0, int f1);
      logic [2*L*W-1:0] v;
      logic [W-1:0] ml, mr;
      v = '0;
      for (int i = 0; i < L; i++) begin
         ml = '0; mr = '0;
         for (int f = f0; f <= f1; f++) begin
            if (ref_mag(tl[f][i]) > ml) ml = ref_mag(tl[f][i]);
            if (ref_mag(tr[f][i]) > mr) mr = ref_mag(tr[f][i]);
         end
         v[i*W +: W]       = ml;
         v[L*W + i*W +: W] = mr;
      end
      return v;
   endfunction

   task automatic fill_frames();
      for (int f = 0; f < NF; f++)
         for (int i = 0; i < L; i++) begin
            tl[f][i] = W'($urandom);
            tr[f][i] = W'($urandom);
         end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ready = 1'b0; ovr_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_fall(int target);
      int b;
      b = 0;
      while (n < target && b < 20000) begin
         @(negedge clk);
         b++;
      end
      if (n < target) begin
         tot_cnt++;
         $display("FAIL wait_fall: reached %0d SCK falls, required %0d", n, target);
      end
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic test_reset();
      fill_frames();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tot_cnt++;
      if ({sck, ws, valid, overrun} !== 4'b0)
         $display("FAIL reset_ctrl: sck/ws/valid/ovr=%b required 0000", {sck, ws, valid, overrun});
      else pass_cnt++;
      tot_cnt++;
      if ({left, right} !== '0)
         $display("FAIL reset_data: left=%h right=%h required 0", left, right);
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_timing();
      int t, first_ws, bad, tog, per;
      int rises[$];
      logic pws, psk;
      do_reset();
      t = 0; first_ws = -1; bad = 0; tog = 0;
      pws = ws; psk = sck;
      while (n < 66 && t < 3000) begin
         @(negedge clk);
         t++;
         if (sck && !psk) rises.push_back(t);
         if (ws !== pws) begin
            tog++;
            if (!(psk && !sck)) bad++;
            if (ws && first_ws < 0) first_ws = n;
         end
         pws = ws; psk = sck;
      end
      per = (rises.size() >= 3) ? rises[2] - rises[1] : -1;
      tot_cnt++;
      if (per !== 2*SH) $display("FAIL sck_period: %0d clk required %0d", per, 2*SH);
      else pass_cnt++;
      tot_cnt++;
      if (first_ws !== 32) $display("FAIL ws_first_rise: at fall %0d required 32", first_ws);
      else pass_cnt++;
      tot_cnt++;
      if (bad !== 0) $display("FAIL ws_on_fall: %0d ws changes off SCK fall, required 0", bad);
      else pass_cnt++;
      tot_cnt++;
      if (tog !== 2) $display("FAIL ws_toggles: %0d in 66 SCK periods, required 2", tog);
      else pass_cnt++;
   endtask

   task automatic test_data();
      rst_n = 1'b0;
      fill_frames();
      tl[0][0] = W'(24'h7FFFFF); tr[0][0] = W'(24'h800001);
      tl[0][1] = W'(24'h123456); tr[0][1] = W'(24'hFEDCBA);
      do_reset();
      wait_fall(LAST);
      repeat (SH) @(negedge clk);   // just after the last-bit capture edge
      tot_cnt++;
      if (valid !== 1'b0) $display("FAIL latency_early: valid=%b required 0", valid);
      else pass_cnt++;
      @(negedge clk);
      tot_cnt++;
      if (valid !== 1'b1) $display("FAIL latency_1clk: valid=%b required 1", valid);
      else pass_cnt++;
      tot_cnt++;
      if (left[W-1:0] !== W'(24'h7FFFFF) || right[2*W-1:W] !== W'(24'hFEDCBA))
         $display("FAIL fixed_slices: left0=%h right1=%h required 7fffff fedcba",
                  left[W-1:0], right[2*W-1:W]);
      else pass_cnt++;
      tot_cnt++;
      if (left !== exp_l(0) || right !== exp_r(0))
         $display("FAIL fixed_frame: left=%h right=%h required %h %h",
                  left, right, exp_l(0), exp_r(0));
      else pass_cnt++;
      pulse_ready();
      for (int f = 1; f <= 3; f++) begin
         wait_fall(64*f + LAST + 1);
         tot_cnt++;
         if (valid !== 1'b1 || overrun !== 1'b0 || left !== exp_l(f) || right !== exp_r(f))
            $display("FAIL rand_frame%0d: v=%b ovr=%b left=%h right=%h required 1 0 %h %h",
                     f, valid, overrun, left, right, exp_l(f), exp_r(f));
         else pass_cnt++;
         pulse_ready();
         tot_cnt++;
         if (valid !== 1'b0) $display("FAIL consume%0d: valid=%b required 0", f, valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_overrun();
      rst_n = 1'b0;
      fill_frames();
      do_reset();
      wait_fall(LAST + 1);
      tot_cnt++;
      if (valid !== 1'b1 || overrun !== 1'b0 || left !== exp_l(0))
         $display("FAIL ovr_f0: v=%b ovr=%b left=%h required 1 0 %h", valid, overrun, left, exp_l(0));
      else pass_cnt++;
      wait_fall(64 + LAST + 1);
      tot_cnt++;
      if (valid !== 1'b1 || overrun !== 1'b1 || left !== exp_l(1) || right !== exp_r(1))
         $display("FAIL ovr_f1: v=%b ovr=%b left=%h right=%h required 1 1 %h %h",
                  valid, overrun, left, right, exp_l(1), exp_r(1));
      else pass_cnt++;
      pulse_ready();
      tot_cnt++;
      if (valid !== 1'b0 || overrun !== 1'b1)
         $display("FAIL ovr_after_ready: v=%b ovr=%b required 0 1", valid, overrun);
      else pass_cnt++;
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      tot_cnt++;
      if (overrun !== 1'b0) $display("FAIL ovr_clr: overrun=%b required 0", overrun);
      else pass_cnt++;
   endtask

   task automatic test_coincide();
      rst_n = 1'b0;
      fill_frames();
      do_reset();
      wait_fall(LAST + 1);
      // ready lands exactly on the frame-1 load edge
      wait_fall(64 + LAST);
      repeat (SH) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      tot_cnt++;
      if (valid !== 1'b1 || overrun !== 1'b0 || left !== exp_l(1) || right !== exp_r(1))
         $display("FAIL coinc_ready: v=%b ovr=%b left=%h right=%h required 1 0 %h %h",
                  valid, overrun, left, right, exp_l(1), exp_r(1));
      else pass_cnt++;
`ifdef I2S_MIC_ARRAY_PEAK_EN
      tot_cnt++;
      if (peak !== exp_pk(1, 1)) $display("FAIL coinc_peak: peak=%h required %h", peak, exp_pk(1, 1));
      else pass_cnt++;
`endif
      // ovr_clr lands on the edge that raises a new overrun
      wait_fall(128 + LAST);
      repeat (SH) @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      tot_cnt++;
      if (overrun !== 1'b1 || left !== exp_l(2))
         $display("FAIL coinc_clr: ovr=%b left=%h required 1 %h", overrun, left, exp_l(2));
      else pass_cnt++;
`ifdef I2S_MIC_ARRAY_PEAK_EN
      tot_cnt++;
      if (peak !== exp_pk(1, 2)) $display("FAIL coinc_peak2: peak=%h required %h", peak, exp_pk(1, 2));
      else pass_cnt++;
`endif
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      fill_frames();
      do_reset();
      wait_fall(64 + 40);
      tot_cnt++;
      if (valid !== 1'b1) $display("FAIL mid_pre: valid=%b required 1", valid);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      tot_cnt++;
      if ({sck, ws, valid, overrun} !== 4'b0 || {left, right} !== '0)
         $display("FAIL mid_async: ctrl=%b left=%h right=%h required all 0",
                  {sck, ws, valid, overrun}, left, right);
      else pass_cnt++;
      fill_frames();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_fall(LAST);
      tot_cnt++;
      if (valid !== 1'b0 || left !== '0)
         $display("FAIL mid_partial: v=%b left=%h required 0 0", valid, left);
      else pass_cnt++;
      wait_fall(LAST + 1);
      tot_cnt++;
      if (valid !== 1'b1 || overrun !== 1'b0 || left !== exp_l(0) || right !== exp_r(0))
         $display("FAIL mid_first: v=%b ovr=%b left=%h right=%h required 1 0 %h %h",
                  valid, overrun, left, right, exp_l(0), exp_r(0));
      else pass_cnt++;
   endtask

`ifdef I2S_MIC_ARRAY_PEAK_EN
   task automatic test_peak();
      rst_n = 1'b0;
      fill_frames();
      tl[0][0] = W'(24'h000100);
      tl[1][0] = W'(24'hFFF000);
      tl[2][0] = W'(24'h800000);
      do_reset();
      wait_fall(128 + LAST + 1);
      tot_cnt++;
      if (peak[W-1:0] !== W'(24'h7FFFFF))
         $display("FAIL peak_sat: peak0=%h required 7fffff", peak[W-1:0]);
      else pass_cnt++;
      tot_cnt++;
      if (peak !== exp_pk(0, 2)) $display("FAIL peak_all: peak=%h required %h", peak, exp_pk(0, 2));
      else pass_cnt++;
      pulse_ready();
      tot_cnt++;
      if (peak !== '0) $display("FAIL peak_clear: peak=%h required 0", peak);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_timing();
      test_data();
      test_overrun();
      test_coincide();
      test_reset_mid();
`ifdef I2S_MIC_ARRAY_PEAK_EN
      test_peak();
`endif
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/i2s_mic_array_receiver.md
Name: i2s_mic_array_receiver

Overview:
- Parametrised, multi-line successor to the single INMP441 I2S receiver used on the board tops.
- Generates SCK and WS as I2S master and deserialises n_lines SD lines. Each line carries a left and a right microphone.
- Presents all channels as one frame word through a valid/ready handshake, with a sticky overrun flag.
- Sits between the GPIO pins and `top`. It replaces the 24-bit single-channel mic path.

Parameters:
- sck_half, 4: clk cycles per SCK half-period. At 27 MHz this gives SCK = 3.375 MHz. Must be ≥ 2.
- w_sample, 24: captured bits per channel, MSB first. Range 1..31.
- n_lines, 2: number of SD data lines. Must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sck  out  1  I2S bit clock.
- ws  out  1  I2S word select: 0 = left, 1 = right.
- sd  in  n_lines  serial data, one bit per line.
- left  out  n_lines*w_sample  left samples; line i occupies [i*w_sample +: w_sample]. Signed, two's complement.
- right  out  n_lines*w_sample  right samples, same packing as left.
- valid  out  1  frame available.
- ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky; a frame was overwritten before it was accepted.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (async assert, sync release): divider=0, bit_cnt=0, sck=0, ws=0, shift/hold regs=0, left=right=0, valid=0, overrun=0.
- Divider counts 0..sck_half-1. On wrap, sck toggles.
  - 0→1 toggle = "rise event".
  - 1→0 toggle = "fall event".
- bit_cnt (6 bits, 0..63) increments on each fall event and wraps 63→0. One frame = 64 SCK periods.
- ws is registered and equals bit_cnt[5]. It therefore changes on a fall event, as I2S requires.
- Capture happens on the rise event, in the same clk cycle:
  - s = bit_cnt, ch = s[5], p = s[4:0].
  - When 1 ≤ p ≤ w_sample, each line shifts sd[i] into its ch shift register, MSB first. This honours the I2S one-SCK MSB delay.
  - For p = 0 and p > w_sample, sd is ignored.
- At rise event with ch=0, p=w_sample: the left shift registers copy into the left hold registers.
- At rise event with ch=1, p=w_sample (frame end): on the next clk edge, left ← hold, right ← right shift regs, valid ← 1.
  - Latency: 1 clk after the last bit is captured.
- Handshake:
  - valid && ready on a clk edge consumes the frame: valid ← 0, unless a frame-end load happens on the same edge.
  - left/right are stable while valid=1 and no new frame loads.
- Frame-end load while valid=1 and ready=0: data is overwritten (newest wins), valid stays 1, overrun ← 1.
- Frame-end load with valid=1 and ready=1 on the same edge: the new frame loads, valid stays 1, no overrun.
- ovr_clr=1 clears overrun on the next edge. If ovr_clr and a new overrun coincide, set wins (overrun=1).
- Reset mid-frame: all state returns to reset values immediately. The partial frame is discarded. The first frame after release starts at bit_cnt=0.
- Elaboration error if sck_half<2, w_sample<1, w_sample>31, or n_lines<1.

Optional Feature:
- Macro: I2S_MIC_ARRAY_PEAK_EN.
- Enabled:
  - Adds output peak of width 2*n_lines*w_sample, same packing as {right, left}.
  - Each channel holds the maximum |sample| seen since the last accepted frame. |min negative| saturates to 2^(w_sample-1)-1.
  - Updated at every frame-end load.
  - On an accepted handshake with no simultaneous load, peak resets to 0.
  - On handshake coincident with a load, peak = |new sample|.
  - Reset value 0.
- Disabled: port and logic absent. All other behaviour is identical.

Test Plan:
- Timing, sck_half=4: after reset, sck period = 8 clk. ws toggles every 32 SCK periods, on falling edges only. First ws 0→1 occurs 32 SCK periods after reset release.
- Data: drive SD model with line0 L=0x7FFFFF, R=0x800001 and line1 L=0x123456, R=0xFEDCBA, MSB one SCK after the ws edge.
  - With ready=1, expect valid 1 clk after the last right bit.
  - Expect the exact values, with left[23:0]=0x7FFFFF and right[47:24]=0xFEDCBA.
- Handshake: hold ready=0 over 2 frames. valid stays 1 and data updates to frame 2 with overrun=1. Then pulse ready: valid→0. Then pulse ovr_clr: overrun→0.
- Coincidence:
  - ready=1 exactly on the frame-end load edge → valid stays 1, new data, overrun stays 0.
  - ovr_clr coincident with an overrun → overrun=1.
- Reset mid-frame: assert rst_n=0 at bit_cnt=40. All outputs drop to 0 asynchronously. After release, the first frame is captured correctly; no partial data appears.
- PEAK_EN on: left samples 0x000100, 0xFFF000, 0x800000 over 3 frames with ready=0. peak[23:0]=0x7FFFFF. After ready, peak[23:0] = 0.
